// File: rtl/addsub_arbiter.sv
// addsub_arbiter: two requesters share one negate unit plus N-bit adder.
// Round-robin grant in IDLE, one operation in flight, registered result
// presented with a valid/ready handshake.

// Two's-complement negate: passes the number through when disabled.
module addsub_arbiter_negate #(
  parameter int unsigned N = 64
) (
  input  logic         i_en,
  input  logic [N-1:0] i_num,
  output logic [N-1:0] o_neg
);

  assign o_neg = i_en ? (~i_num + N'(1)) : i_num;

endmodule

module addsub_arbiter #(
  parameter int unsigned N = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic         req0_sub,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic         req1_sub,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N-1:0] res_data,
  output logic         res_id,
  output logic         res_ovf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;

  logic         r_prio;
  logic [N-1:0] r_a;
  logic [N-1:0] r_b;
  logic         r_sub;
  logic         r_id;

  logic [N-1:0] r_res_data;
  logic         r_res_id;
  logic         r_res_ovf;
  logic         r_res_valid;

  logic         w_grant_vld;
  logic         w_grant_id;
  logic [N-1:0] w_sel_a;
  logic [N-1:0] w_sel_b;
  logic         w_sel_sub;
  logic         w_res_take;

  logic [N-1:0] w_neg;
  logic [N-1:0] w_sum;
  logic         w_b_sign_eff;
  logic         w_ovf;

  // Round-robin grant: priority requester first, otherwise the other one.
  // Ready is withheld while reset is asserted and outside IDLE.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_id  = r_prio;
    if ((r_state == S_IDLE) && !rst) begin
      if (r_prio ? req1_valid : req0_valid) begin
        w_grant_vld = 1'b1;
        w_grant_id  = r_prio;
      end else if (r_prio ? req0_valid : req1_valid) begin
        w_grant_vld = 1'b1;
        w_grant_id  = ~r_prio;
      end
    end
  end

  assign req0_ready = w_grant_vld && !w_grant_id;
  assign req1_ready = w_grant_vld &&  w_grant_id;

  assign w_sel_a   = w_grant_id ? req1_a   : req0_a;
  assign w_sel_b   = w_grant_id ? req1_b   : req0_b;
  assign w_sel_sub = w_grant_id ? req1_sub : req0_sub;

  assign w_res_take = (r_state == S_RESP) && res_ready;

  // Next-state logic for the IDLE -> EXEC -> RESP sequence.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_grant_vld) w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = S_RESP;
      S_RESP:  if (res_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Round-robin pointer: the requester just served drops to second place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prio <= 1'b0;
    end else if (w_res_take) begin
      r_prio <= ~r_res_id;
    end
  end

  // Operand capture on the accept edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_sub <= 1'b0;
      r_id  <= 1'b0;
    end else if (w_grant_vld) begin
      r_a   <= w_sel_a;
      r_b   <= w_sel_b;
      r_sub <= w_sel_sub;
      r_id  <= w_grant_id;
    end
  end

  addsub_arbiter_negate #(
    .N (N)
  ) u_negate (
    .i_en  (r_sub),
    .i_num (r_b),
    .o_neg (w_neg)
  );

  assign w_sum = r_a + w_neg;

  // Overflow uses the sign of the true second operand (-B for subtract)
  // rather than the negate output, so B = most-negative with subtract
  // still reports the real signed overflow of A - B.
  assign w_b_sign_eff = r_sub ? ~r_b[N-1] : r_b[N-1];
  assign w_ovf        = (r_a[N-1] == w_b_sign_eff) && (w_sum[N-1] != r_a[N-1]);

  // Result register: loaded in EXEC, held through RESP until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res_data  <= '0;
      r_res_id    <= 1'b0;
      r_res_ovf   <= 1'b0;
      r_res_valid <= 1'b0;
    end else if (r_state == S_EXEC) begin
      r_res_data  <= w_sum;
      r_res_id    <= r_id;
      r_res_ovf   <= w_ovf;
      r_res_valid <= 1'b1;
    end else if (w_res_take) begin
      r_res_valid <= 1'b0;
    end
  end

  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_id    = r_res_id;
  assign res_ovf   = r_res_ovf;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Scoreboard bench for addsub_arbiter (N=8 main instance, N=64 spot check).
module tb_addsub_arbiter;

  localparam int unsigned N = 8;

  typedef struct {
    logic [7:0] d;
    logic       id;
    logic       ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v0 = 1'b0, v1 = 1'b0, s0 = 1'b0, s1 = 1'b0, rr = 1'b1;
  logic [7:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic        r0, r1, res_valid, res_id, res_ovf;
  logic [7:0]  res_data;

  logic        v64 = 1'b0, s64 = 1'b0;
  logic [63:0] a64 = '0, b64 = '0;
  logic        r64, r64_1, rv64, rid64, rovf64;
  logic [63:0] rd64;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;

  exp_t        sbq[$];
  int          grant_log[$];
  logic        mprio = 1'b0, busy = 1'b0, acc0 = 1'b0, acc1 = 1'b0;
  int          acc_cyc = -1;
  logic        prev_rv = 1'b0, prev_rr = 1'b0, prev_id = 1'b0, prev_ovf = 1'b0;
  logic [7:0]  prev_d = '0;

  addsub_arbiter #(.N(N)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_ready(r0), .req0_a(a0), .req0_b(b0), .req0_sub(s0),
    .req1_valid(v1), .req1_ready(r1), .req1_a(a1), .req1_b(b1), .req1_sub(s1),
    .res_valid(res_valid), .res_ready(rr), .res_data(res_data),
    .res_id(res_id), .res_ovf(res_ovf)
  );

  addsub_arbiter #(.N(64)) u_dut64 (
    .clk(clk), .rst(rst),
    .req0_valid(v64), .req0_ready(r64), .req0_a(a64), .req0_b(b64), .req0_sub(s64),
    .req1_valid(1'b0), .req1_ready(r64_1), .req1_a(64'd0), .req1_b(64'd0), .req1_sub(1'b0),
    .res_valid(rv64), .res_ready(1'b1), .res_data(rd64),
    .res_id(rid64), .res_ovf(rovf64)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: signed arithmetic on plain integers, wrapped to 8 bits.
  function automatic exp_t model(input logic id, input logic [7:0] a, input logic [7:0] b,
                                 input logic sub);
    int   r;
    exp_t e;
    r     = sub ? (int'($signed(a)) - int'($signed(b))) : (int'($signed(a)) + int'($signed(b)));
    e.d   = r[7:0];
    e.id  = id;
    e.ovf = (r > 127) || (r < -128);
    return e;
  endfunction

  function automatic logic [7:0] rnd8();
    case ($urandom_range(0, 5))
      0:       return 8'h80;
      1:       return 8'h7F;
      2:       return 8'h00;
      3:       return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  // Monitor: checks arbitration against a round-robin model, pushes the
  // expected result on every accept, and pops/compares on every result take.
  always @(negedge clk) begin
    logic g;
    exp_t e;
    if (rst) begin
      sbq.delete();
      mprio   = 1'b0;
      busy    = 1'b0;
      prev_rv = 1'b0;
      acc_cyc = -1;
    end else begin
      if (r0) chk("ready0_without_valid", 64'(v0), 64'd1);
      if (r1) chk("ready1_without_valid", 64'(v1), 64'd1);
      if (busy) begin
        if (v0 || v1) chk("ready_while_busy", 64'({r0, r1}), 64'd0);
      end else if (v0 || v1) begin
        g = (v0 && v1) ? mprio : v1;
        chk("grant", 64'({r0, r1}), g ? 64'd1 : 64'd2);
        if (r0 ^ r1) begin
          if (r1) begin
            sbq.push_back(model(1'b1, a1, b1, s1));
            acc1 = 1'b1;
          end else begin
            sbq.push_back(model(1'b0, a0, b0, s0));
            acc0 = 1'b1;
          end
          grant_log.push_back(int'(r1));
          busy    = 1'b1;
          acc_cyc = cyc;
        end
      end
      if (res_valid && !prev_rv && acc_cyc >= 0)
        chk("latency", 64'(cyc - acc_cyc), 64'd2);
      if (res_valid && prev_rv && !prev_rr) begin
        chk("hold_data", 64'(res_data), 64'(prev_d));
        chk("hold_id",   64'(res_id),   64'(prev_id));
        chk("hold_ovf",  64'(res_ovf),  64'(prev_ovf));
      end
      if (res_valid && !busy) chk("unexpected_result", 64'(res_valid), 64'd0);
      if (res_valid && rr) begin
        chk("scoreboard_nonempty", 64'(sbq.size() != 0), 64'd1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          chk("res_data", 64'(res_data), 64'(e.d));
          chk("res_id",   64'(res_id),   64'(e.id));
          chk("res_ovf",  64'(res_ovf),  64'(e.ovf));
          mprio = ~e.id;
        end
        busy = 1'b0;
      end
      prev_rv  = res_valid;
      prev_rr  = rr;
      prev_d   = res_data;
      prev_id  = res_id;
      prev_ovf = res_ovf;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic id, input logic [7:0] a, input logic [7:0] b, input logic sub);
    logic got;
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (id) begin v1 = 1'b1; a1 = a; b1 = b; s1 = sub; end
    else    begin v0 = 1'b1; a0 = a; b0 = b; s0 = sub; end
    for (int i = 0; i < 40; i++) begin
      step();
      if (id ? acc1 : acc0) break;
    end
    got = id ? acc1 : acc0;
    chk("send_accept", 64'(got), 64'd1);
    if (id) v1 = 1'b0; else v0 = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      step();
      if (!busy && sbq.size() == 0 && !res_valid) break;
    end
    chk("drain", 64'(busy), 64'd0);
  endtask

  task automatic op64(input logic [63:0] a, input logic [63:0] b, input logic sub,
                      input logic [63:0] ed, input logic eovf);
    v64 = 1'b1; a64 = a; b64 = b; s64 = sub;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (r64) break;
    end
    chk("n64_accept", 64'(r64), 64'd1);
    @(posedge clk);
    #1 v64 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rv64) break;
    end
    chk("n64_valid", 64'(rv64), 64'd1);
    chk("n64_data", rd64, ed);
    chk("n64_ovf", 64'(rovf64), 64'(eovf));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic first0;
    // Reset state, with both valids raised to confirm ready stays low.
    v0 = 1'b1; v1 = 1'b1;
    #3;
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_data",  64'(res_data),  64'd0);
    chk("rst_res_id",    64'(res_id),    64'd0);
    chk("rst_res_ovf",   64'(res_ovf),   64'd0);
    chk("rst_ready",     64'({r0, r1}),  64'd0);
    v0 = 1'b0; v1 = 1'b0;
    step(); step();
    rst = 1'b0;

    // Directed arithmetic, including boundary operands.
    send(1'b0, 8'd5, 8'd3, 1'b0);        wait_idle();
    send(1'b1, 8'd3, 8'd5, 1'b1);        wait_idle();
    send(1'b1, 8'h7F, 8'h01, 1'b0);      wait_idle();
    send(1'b1, 8'h00, 8'h80, 1'b1);      wait_idle();
    send(1'b1, 8'hC5, 8'h80, 1'b1);      wait_idle();
    send(1'b1, 8'h37, 8'h00, 1'b1);      wait_idle();

    // Both requesters continuously valid: grants must alternate from 0.
    grant_log.delete();
    acc0 = 1'b0; acc1 = 1'b0; rr = 1'b1;
    v0 = 1'b1; a0 = rnd8(); b0 = rnd8(); s0 = 1'($urandom);
    v1 = 1'b1; a1 = rnd8(); b1 = rnd8(); s1 = 1'($urandom);
    repeat (18) begin
      step();
      if (acc0) begin acc0 = 1'b0; a0 = rnd8(); b0 = rnd8(); s0 = 1'($urandom); end
      if (acc1) begin acc1 = 1'b0; a1 = rnd8(); b1 = rnd8(); s1 = 1'($urandom); end
    end
    v0 = 1'b0; v1 = 1'b0;
    wait_idle();
    chk("rr_count", 64'(grant_log.size() >= 6), 64'd1);
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      chk("rr_order", 64'(grant_log[i]), 64'(i % 2));

    // Consumer stalls in RESP: nothing else may be accepted meanwhile.
    rr = 1'b0; acc0 = 1'b0; acc1 = 1'b0;
    v0 = 1'b1; a0 = rnd8(); b0 = rnd8(); s0 = 1'b0;
    v1 = 1'b1; a1 = rnd8(); b1 = rnd8(); s1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (acc0 || acc1) break;
    end
    chk("stall_first_accept", 64'(acc0 | acc1), 64'd1);
    first0 = acc0;
    acc0 = 1'b0; acc1 = 1'b0;
    repeat (7) begin
      step();
      chk("stall_no_accept", 64'(acc0 | acc1), 64'd0);
    end
    rr = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (acc0 || acc1) break;
    end
    chk("stall_second_port", 64'(acc0), 64'(!first0));
    v0 = 1'b0; v1 = 1'b0;
    wait_idle();

    // Reset in EXEC: result abandoned, registers cleared at once, prio back to 0.
    send(1'b0, 8'h11, 8'h22, 1'b0);
    wait_idle();
    acc0 = 1'b0;
    v0 = 1'b1; a0 = 8'h40; b0 = 8'h01; s0 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (acc0) break;
    end
    chk("rst_op_accept", 64'(acc0), 64'd1);
    v0 = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_res_valid", 64'(res_valid), 64'd0);
    chk("async_res_data",  64'(res_data),  64'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    repeat (6) begin
      step();
      chk("no_result_after_rst", 64'(res_valid), 64'd0);
    end
    acc0 = 1'b0; acc1 = 1'b0;
    v0 = 1'b1; a0 = rnd8(); b0 = rnd8(); s0 = 1'b1;
    v1 = 1'b1; a1 = rnd8(); b1 = rnd8(); s1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (acc0 || acc1) break;
    end
    chk("post_rst_grant0", 64'({acc0, acc1}), 64'd2);
    v0 = 1'b0; v1 = 1'b0;
    wait_idle();

    // Wide datapath spot checks.
    op64(64'd0, 64'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    op64(64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);

    // Randomized traffic with random consumer back-pressure.
    acc0 = 1'b0; acc1 = 1'b0;
    for (int c = 0; c < 500; c++) begin
      step();
      if (acc0 || !v0) begin
        acc0 = 1'b0;
        v0 = ($urandom_range(0, 3) != 0);
        a0 = rnd8(); b0 = rnd8(); s0 = 1'($urandom);
      end
      if (acc1 || !v1) begin
        acc1 = 1'b0;
        v1 = ($urandom_range(0, 3) != 0);
        a1 = rnd8(); b1 = rnd8(); s1 = 1'($urandom);
      end
      rr = ($urandom_range(0, 3) != 0);
    end
    v0 = 1'b0; v1 = 1'b0; rr = 1'b1;
    wait_idle();
    chk("queue_empty", 64'(sbq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
